l1_mmu_arbiter: RTL
===================

L1_MMU_ARBITER -- requirements
Module: l1_mmu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports below.
- sys_clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-002 The block SHALL provide the L1I client ports:
- ic_req_read  in  1  L1I line read request, level, held until ic_done.
- ic_req_addr  in  32  L1I line address.
- ic_done  out  1  one-cycle completion pulse to L1I.
- ic_read_data  out  256  returned line, valid while ic_done=1.
REQ-003 The block SHALL provide the L1D client ports:
- dc_req_read  in  1  L1D line read request, level, held until dc_done.
- dc_req_write  in  1  L1D line write-back request, level, held until dc_done.
- dc_req_addr  in  32  L1D line address.
- dc_write_data  in  256  write-back line.
- dc_done  out  1  one-cycle completion pulse to L1D.
- dc_read_data  out  256  returned line, valid while dc_done=1.
REQ-004 The block SHALL provide the l1mmu-side ports:
- mmu_req_read  out  1  registered read request.
- mmu_req_write  out  1  registered write request.
- mmu_req_addr  out  32  registered address.
- mmu_write_data  out  256  registered write line.
- mmu_done  in  1  l1mmu completion pulse.
- mmu_read_data  in  256  l1mmu line, valid with mmu_done.

Function
REQ-005 The FSM SHALL have four states: IDLE, SERVE_IC, SERVE_DC, RESP.
REQ-006 In IDLE with any request pending, the FSM SHALL grant one client and, on the same edge, register that client's request, address, and write data onto the mmu_* outputs, so that mmu_req_* is asserted in the cycle after the request is first seen.
REQ-007 In SERVE_IC or SERVE_DC, the mmu_* outputs SHALL hold constant, and client request changes SHALL be ignored, until mmu_done=1.
REQ-008 On an mmu_done edge, the block SHALL deassert mmu_req_read and mmu_req_write, latch mmu_read_data into the granted client's read-data register, pulse only that client's done signal for exactly one cycle, and enter RESP.
REQ-009 RESP SHALL last exactly one cycle, SHALL ignore all requests, and SHALL return to IDLE; re-arbitration therefore occurs no earlier than two cycles after mmu_done.
REQ-010 mmu_done received in IDLE or RESP SHALL be ignored, with no done pulse and no state change.
REQ-011 If dc_req_read and dc_req_write are both high, the block SHALL forward a write only (mmu_req_read=0).
REQ-012 mmu_req_read and mmu_req_write SHALL never be high together, and ic_done and dc_done SHALL never be high together.
REQ-013 ic_read_data and dc_read_data SHALL hold their last latched value between done pulses.
REQ-014 A last_grant flag SHALL record the most recently granted client on each grant.

Reset
REQ-015 While rst=1 at an edge, the block SHALL set state=IDLE, all mmu_req_* and done outputs=0, mmu_req_addr=0, all 256-bit data registers=0, and last_grant=DC, regardless of any transaction in flight.
REQ-016 After rst deasserts, the first IDLE cycle SHALL arbitrate normally; a stale mmu_done for an aborted transaction SHALL be ignored under REQ-010.

Configuration
REQ-017 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: when both clients request in IDLE, grant the client that is not last_grant; a single requester is always granted.
- Undefined: fixed priority, with L1I always winning when both request; last_grant is still updated but does not affect the grant.

Verification
REQ-018 Reset, then ic_req_read=1 with addr=0x0000_1000; l1mmu returns mmu_done three cycles after mmu_req_read with data=0xA5 repeated -> mmu_req_read rises one cycle after the request, ic_done pulses one cycle after mmu_done with ic_read_data=0xA5..A5, and dc_done stays 0.
REQ-019 With ic_req_read and dc_req_read raised in the same cycle after reset -> L1I is served first. With the clients re-requesting back-to-back: under ARB_ROUND_ROBIN_EN the grants alternate IC, DC, IC; without the macro, IC is granted every time.
REQ-020 dc_req_write=1 with addr=0x0000_2000 and write_data=0x1234..; partway through, change dc_req_addr to 0x3000 -> mmu_req_addr stays 0x2000 and mmu_write_data is unchanged until mmu_done.
REQ-021 Inject mmu_done while in IDLE, and again in the RESP cycle -> no done pulse is produced and the state is unchanged.
REQ-022 Assert rst while in SERVE_DC, then send mmu_done one cycle after rst falls -> all outputs are 0 the cycle after rst, dc_done never pulses, and the FSM is in IDLE.
REQ-023 Drive dc_req_read and dc_req_write both high -> mmu_req_write=1 and mmu_req_read=0 for the whole transaction.

Source files
------------

// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter: shares the single l1mmu line port between the L1I and L1D
// clients. One transaction is in flight at a time. Every mmu_* request and
// client done/data output is a register.
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate between the clients. When undefined, L1I has fixed
// priority.
module l1_mmu_arbiter (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         ic_req_read,
    input  logic [31:0]  ic_req_addr,
    output logic         ic_done,
    output logic [255:0] ic_read_data,
    input  logic         dc_req_read,
    input  logic         dc_req_write,
    input  logic [31:0]  dc_req_addr,
    input  logic [255:0] dc_write_data,
    output logic         dc_done,
    output logic [255:0] dc_read_data,
    output logic         mmu_req_read,
    output logic         mmu_req_write,
    output logic [31:0]  mmu_req_addr,
    output logic [255:0] mmu_write_data,
    input  logic         mmu_done,
    input  logic [255:0] mmu_read_data
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SERVE_IC, SERVE_DC, RESP} state_t;
    typedef enum logic {GRANT_IC, GRANT_DC} client_t;

    state_t  state;
    client_t last_grant;
    logic    ic_pending;
    logic    dc_pending;
    logic    pick_ic;

    // Arbitration decision, used only when the FSM is in IDLE.
    // In fixed priority mode, last_grant is tracked but never consulted.
    always_comb begin
        ic_pending = ic_req_read;
        dc_pending = dc_req_read | dc_req_write;
        pick_ic    = ic_pending && (!dc_pending || !ROUND_ROBIN || last_grant == GRANT_DC);
    end

    // Transaction FSM. It grants a client, holds the mmu request, and returns
    // the line with a one-cycle done pulse.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= GRANT_DC;
            mmu_req_read   <= 1'b0;
            mmu_req_write  <= 1'b0;
            mmu_req_addr   <= '0;
            mmu_write_data <= '0;
            ic_done        <= 1'b0;
            dc_done        <= 1'b0;
            ic_read_data   <= '0;
            dc_read_data   <= '0;
        end else begin
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_pending || dc_pending) begin
                        if (pick_ic) begin
                            state          <= SERVE_IC;
                            last_grant     <= GRANT_IC;
                            mmu_req_read   <= 1'b1;
                            mmu_req_write  <= 1'b0;
                            mmu_req_addr   <= ic_req_addr;
                            mmu_write_data <= '0;
                        end else begin
                            state          <= SERVE_DC;
                            last_grant     <= GRANT_DC;
                            // A write-back wins over a read that is raised at the same time.
                            mmu_req_read   <= dc_req_read & ~dc_req_write;
                            mmu_req_write  <= dc_req_write;
                            mmu_req_addr   <= dc_req_addr;
                            mmu_write_data <= dc_write_data;
                        end
                    end
                end
                SERVE_IC: begin
                    if (mmu_done) begin
                        state         <= RESP;
                        mmu_req_read  <= 1'b0;
                        mmu_req_write <= 1'b0;
                        ic_read_data  <= mmu_read_data;
                        ic_done       <= 1'b1;
                    end
                end
                SERVE_DC: begin
                    if (mmu_done) begin
                        state         <= RESP;
                        mmu_req_read  <= 1'b0;
                        mmu_req_write <= 1'b0;
                        dc_read_data  <= mmu_read_data;
                        dc_done       <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
